mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Upstream sequencer for the 4:1 structural mux. It drives the mux select lines s1/s0 through channels 0..3 and holds each channel for a programmable dwell time. On the last dwell cycle of each channel it samples the mux output d, and after all four channels it presents the result as one 4-bit snapshot with a one-cycle valid pulse. The mux data inputs i0..i3 are driven by the surrounding design, not by this block.

Parameters:
DWELL, 4, clock cycles each channel is held selected; legal range 1..255.
CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request one scan; sampled only in IDLE.
d  input  1  output of the 4:1 mux under control.
s1  output  1  mux select MSB (registered).
s0  output  1  mux select LSB (registered).
sample  output  4  last completed snapshot; sample[n] = d captured while channel n was selected.
valid  output  1  one-cycle pulse; sample was updated on the preceding edge.
busy  output  1  high while a scan is in progress (SCAN or DONE).

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset). Reset dominates all other inputs on the same edge.
- Reset values: state=IDLE, s1=0, s0=0, sample=4'b0000, valid=0, busy=0, channel=0, dwell_cnt=0, shadow=3'b000.
- States: IDLE, SCAN, DONE.
- IDLE:
  - s1/s0 held at 2'b00; busy=0.
  - start=1 at edge E0 -> SCAN with ch=0, cnt=0, busy=1.
- SCAN:
  - {s1,s0} = ch, registered; selects change only on edges.
  - Each edge: cnt increments.
  - When cnt==DWELL-1: capture d into shadow[ch] and set cnt=0.
    - If ch<3: ch increments.
    - If ch==3: sample <= {d, shadow[2:0]} and go to DONE.
- Timing:
  - Channel n is selected during edges E0+n*DWELL .. E0+(n+1)*DWELL-1.
  - Channel n is captured at edge E0+(n+1)*DWELL.
  - With DWELL=1, d is sampled exactly one cycle after the select changes; the mux path is combinational, so this is legal.
- DONE:
  - Lasts one cycle: valid=1, busy=1, s1/s0 return to 2'b00.
  - Next edge -> IDLE with valid=0.
  - valid is high in the cycle after edge E0+4*DWELL. Total start-to-valid latency is 4*DWELL edges.
- start while busy (SCAN or DONE): ignored; no queueing.
- sample is stable outside the update edge and holds its value through IDLE and subsequent scans until the next ch3 capture.
- Reset mid-scan: the scan is abandoned and shadow bits are discarded. sample clears to 0 and no valid is produced.
- Counter and channel wrap: ch never exceeds 3 and cnt never exceeds DWELL-1.

Optional Feature:
MUX_SCAN_CONTINUOUS_EN
- Defined: in DONE, start is treated as a run level.
  - start=1 during DONE -> next edge goes straight to SCAN at ch=0, cnt=0; busy stays 1.
  - valid then pulses every 4*DWELL+1 cycles for as long as start stays high.
  - start=0 during DONE -> IDLE.
- Undefined: DONE always goes to IDLE. A new scan needs start=1 sampled in IDLE, so back-to-back scans are 4*DWELL+2 cycles apart at best.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> s1=s0=0, sample=0000, valid=0, busy=0 throughout.
- DWELL=4, i0..i3=1,0,1,1, one-cycle start -> selects step 00,01,10,11 every 4 cycles; valid high exactly 16 edges after start edge; sample=4'b1101; busy=0 one cycle later.
- DWELL=1, i0..i3=0,1,1,0 -> each select value lasts one cycle; valid 4 edges after start; sample=4'b0110.
- Start pulsed again at channel 2 of a running scan (DWELL=4) -> ignored; only one valid pulse; next scan requires start in IDLE.
- Reset asserted at edge E0+6 of a DWELL=4 scan with prior sample=1111 -> next cycle sample=0000, s1=s0=0, busy=0, no valid pulse.
- MUX_SCAN_CONTINUOUS_EN defined, DWELL=2, start held high, i3 toggled between scans -> valid every 9 cycles, busy continuously 1, sample[3] follows i3; start dropped -> returns to IDLE after current DONE.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through channels 0..3, dwells DWELL cycles on each, and snapshots d into a 4-bit sample.
// Optional build macro MUX_SCAN_CONTINUOUS_EN: a start held high in DONE chains straight into the next scan.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       d,
  output logic       s1,
  output logic       s0,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           state;
  state_t           state_next;
  logic [1:0]       ch;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       shadow;
  logic             last_dwell;

  assign last_dwell = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: if (last_dwell && (ch == 2'd3)) state_next = DONE;
      DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        state_next = start ? SCAN : IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // ch doubles as the registered select value, so it is parked at 0 outside SCAN
  always_ff @(posedge clk) begin
    if (reset) begin
      ch     <= 2'd0;
      cnt    <= '0;
      shadow <= 3'b000;
      sample <= 4'b0000;
    end else begin
      case (state)
        SCAN: begin
          if (last_dwell) begin
            cnt <= '0;
            if (ch == 2'd3) begin
              sample <= {d, shadow};
              ch     <= 2'd0;
            end else begin
              shadow[ch] <= d;
              ch         <= ch + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          ch  <= 2'd0;
          cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s1    = ch[1];
    s0    = ch[0];
    valid = (state == DONE);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: three instances (DWELL 4, 1, 2) checked every cycle against
// an arithmetic model of the scan timeline, plus literal spot checks on latency, snapshots and reset.
module tb_mux_scan_ctrl;

  localparam int DW [3] = '{4, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] ins [3];
  logic       dv [3];
  logic       s1v [3];
  logic       s0v [3];
  logic       validv [3];
  logic       busyv [3];
  logic [3:0] samplev [3];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    assign dv[g] = ins[g][{s1v[g], s0v[g]}];
    mux_scan_ctrl #(.DWELL(DW[g]), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .d(dv[g]),
      .s1(s1v[g]), .s0(s0v[g]), .sample(samplev[g]),
      .valid(validv[g]), .busy(busyv[g])
    );
  end

  // Model: k counts edges since the start edge; a scan spans k=0..4*DWELL, the last being DONE
  bit         m_active [3];
  int         m_k [3];
  logic [3:0] m_cap [3];
  logic [3:0] m_sample [3];

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        m_active[g] = 1'b0;
        m_k[g] = 0;
        m_sample[g] = 4'b0000;
      end else if (!m_active[g]) begin
        if (start) begin
          m_active[g] = 1'b1;
          m_k[g] = 0;
        end
      end else if (m_k[g] < 4 * DW[g]) begin
        if ((m_k[g] + 1) % DW[g] == 0) m_cap[g][m_k[g] / DW[g]] = ins[g][m_k[g] / DW[g]];
        m_k[g] = m_k[g] + 1;
        if (m_k[g] == 4 * DW[g]) m_sample[g] = m_cap[g];
      end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        if (start) m_k[g] = 0;
        else m_active[g] = 1'b0;
`else
        m_active[g] = 1'b0;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input int g, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d actual=%0d required=%0d at %0t", name, g, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 3; g++) begin
        bit in_done;
        int exp_sel;
        in_done = m_active[g] && (m_k[g] == 4 * DW[g]);
        exp_sel = (m_active[g] && !in_done) ? m_k[g] / DW[g] : 0;
        checkOutput("sel", g, int'({s1v[g], s0v[g]}), exp_sel);
        checkOutput("busy", g, int'(busyv[g]), int'(m_active[g]));
        checkOutput("valid", g, int'(validv[g]), int'(in_done));
        checkOutput("sample", g, int'(samplev[g]), int'(m_sample[g]));
      end
    end
  end

  int lat [3];
  int vcount [3];

  // One start pulse, then watch 40 cycles; again_at re-pulses start mid-scan
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input int again_at);
    ins[0] = a;
    ins[1] = b;
    ins[2] = c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      lat[g] = -1;
      vcount[g] = 0;
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == again_at);
      for (int g = 0; g < 3; g++) begin
        if (validv[g]) begin
          vcount[g]++;
          if (lat[g] < 0) lat[g] = n;
        end
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int last_v;
    reset = 1'b1;
    start = 1'b0;
    for (int g = 0; g < 3; g++) ins[g] = 4'b0000;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checkOutput("idle_sample", 0, int'(samplev[0]), 0);
      checkOutput("idle_busy", 0, int'(busyv[0]), 0);
      checkOutput("idle_valid", 0, int'(validv[0]), 0);
      checkOutput("idle_sel", 0, int'({s1v[0], s0v[0]}), 0);
    end

    applyStimulus(4'b1101, 4'b0110, 4'b1010, -1);
    checkOutput("latency", 0, lat[0], 16);
    checkOutput("latency", 1, lat[1], 4);
    checkOutput("latency", 2, lat[2], 8);
    checkOutput("snap", 0, int'(samplev[0]), 13);
    checkOutput("snap", 1, int'(samplev[1]), 6);
    checkOutput("snap", 2, int'(samplev[2]), 10);
    checkOutput("busy_after", 0, int'(busyv[0]), 0);

    applyStimulus(4'b0011, 4'b1001, 4'b0101, 9);
    checkOutput("one_valid", 0, vcount[0], 1);
    checkOutput("snap2", 0, int'(samplev[0]), 3);

    applyStimulus(4'b1111, 4'b1111, 4'b1111, -1);
    checkOutput("snap_ones", 0, int'(samplev[0]), 15);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_sample", 0, int'(samplev[0]), 0);
    checkOutput("rst_busy", 0, int'(busyv[0]), 0);
    checkOutput("rst_valid", 0, int'(validv[0]), 0);
    checkOutput("rst_sel", 0, int'({s1v[0], s0v[0]}), 0);

    // Hold start high and measure the valid pulse spacing on the DWELL=2 instance
    last_v = -1;
    start = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n % 9 == 4) ins[2][3] = ~ins[2][3];
      if (validv[2]) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        if (last_v >= 0) checkOutput("valid_period", 2, n - last_v, 9);
`else
        if (last_v >= 0) checkOutput("valid_period", 2, n - last_v, 10);
`endif
        last_v = n;
      end
`ifdef MUX_SCAN_CONTINUOUS_EN
      checkOutput("busy_cont", 2, int'(busyv[2]), 1);
`endif
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("busy_drop", 2, int'(busyv[2]), 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 299) == 0);
      for (int g = 0; g < 3; g++) if ($urandom_range(0, 3) == 0) ins[g] = 4'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
